// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming K x K pooling stage (max or average) with a fused
// row line buffer. The input is a raster stream of pixels, one per accepted
// beat, with all feature maps side by side. One pooled pixel is emitted per
// completed window, and out_last marks the final window of each frame.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   flush      synchronous frame abort; clears position, state and output
//   in_valid   input pixel valid
//   in_ready   block accepts a pixel this cycle
//   in_act     input pixel, channel c at [c*BITWIDTH +: BITWIDTH]
//   out_valid  pooled pixel valid
//   out_ready  downstream accepts the pooled pixel
//   out_act    pooled pixel, same channel packing as in_act
//   out_last   qualifies out_valid: last pooled pixel of the frame
module pool2d_stream #(
   parameter int BITWIDTH = 16,
   parameter int NFMAPS   = 6,
   parameter int KER_SIZE = 2,
   parameter int STRIDE   = 2,
   parameter int NW       = 28,
   parameter int NH       = 28,
   parameter int MODE     = 0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NFMAPS*BITWIDTH-1:0] in_act,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NFMAPS*BITWIDTH-1:0] out_act,
   output logic                       out_last
);

   localparam int PW     = NFMAPS * BITWIDTH;
   localparam int CW     = (NW > 1) ? $clog2(NW) : 1;
   localparam int RW     = (NH > 1) ? $clog2(NH) : 1;
   localparam int LOG2K  = $clog2(KER_SIZE);
   localparam int SW     = BITWIDTH + 2 * LOG2K;
   localparam int LBR    = (KER_SIZE > 1) ? KER_SIZE - 1 : 1;
   // Bottom-right corner of the last window that fits when the stride does
   // not land exactly on the image edge.
   localparam int LAST_R = KER_SIZE - 1 + ((NH - KER_SIZE) / STRIDE) * STRIDE;
   localparam int LAST_C = KER_SIZE - 1 + ((NW - KER_SIZE) / STRIDE) * STRIDE;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

   state_t          r_state, w_state_nx;
   logic [CW-1:0]   r_col;
   logic [RW-1:0]   r_row;
   logic            r_out_valid, r_out_last;
   logic [PW-1:0]   r_out_act;
   logic [PW-1:0]   r_lb  [LBR][NW];
   logic [PW-1:0]   r_win [KER_SIZE][KER_SIZE];
   logic [PW-1:0]   w_win_nx [KER_SIZE][KER_SIZE];
   logic [PW-1:0]   w_pool;
   logic            w_accept, w_col_end, w_row_end, w_frame_end, w_at_kk;
   logic            w_rows_ok, w_col_ph_ok, w_row_ph_ok, w_complete, w_is_last;

   // Single output register without a skid buffer: stall as soon as it is full.
   assign in_ready    = (!r_out_valid || out_ready) && !flush;
   assign w_accept    = in_valid && in_ready;
   assign w_col_end   = (r_col == CW'(NW - 1));
   assign w_row_end   = (r_row == RW'(NH - 1));
   assign w_frame_end = w_col_end && w_row_end;
   assign w_at_kk     = (r_row == RW'(KER_SIZE - 1)) && (r_col == CW'(KER_SIZE - 1));
   assign w_col_ph_ok = (int'(r_col) >= KER_SIZE - 1) &&
                        ((int'(r_col) - (KER_SIZE - 1)) % STRIDE == 0);
   assign w_row_ph_ok = ((int'(r_row) - (KER_SIZE - 1)) % STRIDE == 0);
   assign w_complete  = w_rows_ok && w_col_ph_ok && w_row_ph_ok;
   assign w_is_last   = (r_row == RW'(LAST_R)) && (r_col == CW'(LAST_C));

   assign out_valid = r_out_valid;
   assign out_act   = r_out_act;
   assign out_last  = r_out_last;

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the pre-edge values, whatever the process order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      r_state <= ST_IDLE;
      else if (flush) r_state <= ST_IDLE;
      else            r_state <= w_state_nx;
   end

   // NOTE: default assignment first, so no path through the block leaves the
   // output unassigned and infers a latch.
   always_comb begin
      w_state_nx = r_state;
      if (w_accept) begin
         unique case (r_state)
            ST_IDLE: w_state_nx = w_frame_end ? ST_IDLE : (w_at_kk ? ST_RUN : ST_FILL);
            ST_FILL: w_state_nx = w_frame_end ? ST_IDLE : (w_at_kk ? ST_RUN : ST_FILL);
            ST_RUN:  w_state_nx = w_frame_end ? ST_IDLE : ST_RUN;
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   // Rows r >= K-1 are reached exactly when RUN is entered at (K-1, K-1).
   always_comb begin
      w_rows_ok = (r_state == ST_RUN) || w_at_kk;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_col <= '0;
         r_row <= '0;
      end else if (flush) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Next window: shift columns left, the new right column comes from the
   // stored rows above plus the incoming pixel.
   always_comb begin
      for (int i = 0; i < KER_SIZE; i++) begin
         for (int j = 0; j < KER_SIZE - 1; j++) w_win_nx[i][j] = r_win[i][j+1];
      end
      for (int i = 0; i < KER_SIZE - 1; i++) w_win_nx[i][KER_SIZE-1] = r_lb[i][r_col];
      w_win_nx[KER_SIZE-1][KER_SIZE-1] = in_act;
   end

   // NOTE: line buffer and window are storage with no reset; their content is
   // never used before it has been written in the current frame.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < KER_SIZE; i++)
            for (int j = 0; j < KER_SIZE; j++) r_win[i][j] <= w_win_nx[i][j];
      end
   end

   // Row i of the buffer holds image row r-(K-1)+i; each write ages the column.
   if (KER_SIZE > 1) begin : g_lb
      always_ff @(posedge clk) begin
         if (w_accept) begin
            for (int i = 0; i < KER_SIZE - 2; i++) r_lb[i][r_col] <= r_lb[i+1][r_col];
            r_lb[KER_SIZE-2][r_col] <= in_act;
         end
      end
   end

   always_comb begin
      logic signed [BITWIDTH-1:0] v_val, v_max;
      logic signed [SW-1:0]       v_sum, v_avg;
      w_pool = '0;
      v_val  = '0;
      v_max  = '0;
      v_sum  = '0;
      v_avg  = '0;
      for (int ch = 0; ch < NFMAPS; ch++) begin
         v_max = $signed(w_win_nx[0][0][ch*BITWIDTH +: BITWIDTH]);
         v_sum = '0;
         for (int i = 0; i < KER_SIZE; i++) begin
            for (int j = 0; j < KER_SIZE; j++) begin
               v_val = $signed(w_win_nx[i][j][ch*BITWIDTH +: BITWIDTH]);
               if (v_val > v_max) v_max = v_val;
               v_sum = v_sum + SW'(v_val);
            end
         end
         // Arithmetic shift floors toward -inf; the mean always fits BITWIDTH.
         v_avg = v_sum >>> (2 * LOG2K);
         w_pool[ch*BITWIDTH +: BITWIDTH] = (MODE == 1) ? v_avg[BITWIDTH-1:0] : v_max;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out_valid <= 1'b0;
         r_out_act   <= '0;
         r_out_last  <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_accept && w_complete) begin
         r_out_valid <= 1'b1;
         r_out_act   <= w_pool;
         r_out_last  <= w_is_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: three instances (4x4 K2 S2 max, same in average
// mode, 3x3 K2 S1 max) driven with ramps and random frames, compared with a
// window-by-window reference model of pooling over a stored frame.
module tb_pool2d_stream;

   localparam int B  = 16;
   localparam int NF = 2;
   localparam int PW = NF * B;

   typedef struct packed {
      logic [PW-1:0] act;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic          ab_flush, ab_in_valid, ab_out_ready;
   logic [PW-1:0] ab_in_act;
   logic          a_in_ready, a_out_valid, a_out_last;
   logic          b_in_ready, b_out_valid, b_out_last;
   logic [PW-1:0] a_out_act, b_out_act;
   logic          c_flush, c_in_valid, c_out_ready, c_in_ready, c_out_valid, c_out_last;
   logic [PW-1:0] c_in_act, c_out_act;

   pool2d_stream #(.BITWIDTH(B), .NFMAPS(NF), .KER_SIZE(2), .STRIDE(2), .NW(4), .NH(4), .MODE(0)) u_a (
      .clk(clk), .rstn(rstn), .flush(ab_flush), .in_valid(ab_in_valid), .in_ready(a_in_ready),
      .in_act(ab_in_act), .out_valid(a_out_valid), .out_ready(ab_out_ready), .out_act(a_out_act),
      .out_last(a_out_last));

   pool2d_stream #(.BITWIDTH(B), .NFMAPS(NF), .KER_SIZE(2), .STRIDE(2), .NW(4), .NH(4), .MODE(1)) u_b (
      .clk(clk), .rstn(rstn), .flush(ab_flush), .in_valid(ab_in_valid), .in_ready(b_in_ready),
      .in_act(ab_in_act), .out_valid(b_out_valid), .out_ready(ab_out_ready), .out_act(b_out_act),
      .out_last(b_out_last));

   pool2d_stream #(.BITWIDTH(B), .NFMAPS(NF), .KER_SIZE(2), .STRIDE(1), .NW(3), .NH(3), .MODE(0)) u_c (
      .clk(clk), .rstn(rstn), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_act(c_in_act), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_act(c_out_act),
      .out_last(c_out_last));

   exp_t          qa[$], qb[$], qc[$];
   exp_t          ea, eb, ec;
   logic [PW-1:0] frm [64];
   int            total = 0;
   int            bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic int chv(input logic [PW-1:0] px, input int ch);
      logic signed [B-1:0] s;
      s = px[ch*B +: B];
      return int'(s);
   endfunction

   // Reference: walk every window position of the stored frame directly.
   task automatic gen(input int nw, input int nh, input int k, input int s, input int mode, input int q);
      int   nout, n, mx, sum, v, res;
      exp_t e;
      nout = ((nw - k) / s + 1) * ((nh - k) / s + 1);
      n    = 0;
      for (int r = k - 1; r < nh; r += s) begin
         for (int c = k - 1; c < nw; c += s) begin
            e.act = '0;
            for (int ch = 0; ch < NF; ch++) begin
               mx  = chv(frm[(r-k+1)*nw + (c-k+1)], ch);
               sum = 0;
               for (int i = 0; i < k; i++) begin
                  for (int j = 0; j < k; j++) begin
                     v = chv(frm[(r-k+1+i)*nw + (c-k+1+j)], ch);
                     if (v > mx) mx = v;
                     sum += v;
                  end
               end
               if (mode == 1) begin
                  res = sum / (k * k);
                  if ((sum % (k * k) != 0) && (sum < 0)) res -= 1;
               end else begin
                  res = mx;
               end
               e.act[ch*B +: B] = 16'(res);
            end
            n++;
            e.last = (n == nout);
            if (q == 0) qa.push_back(e);
            else if (q == 1) qb.push_back(e);
            else qc.push_back(e);
         end
      end
   endtask

   task automatic push_model(input int grp);
      if (grp == 0) begin
         gen(4, 4, 2, 2, 0, 0);
         gen(4, 4, 2, 2, 1, 1);
      end else begin
         gen(3, 3, 2, 1, 0, 2);
      end
   endtask

   task automatic fill_ramp(input int nw, input int nh);
      for (int p = 0; p < nw * nh; p++) frm[p] = {16'(-p), 16'(p)};
   endtask

   task automatic fill_rand(input int n);
      int sel;
      for (int p = 0; p < n; p++) begin
         for (int ch = 0; ch < NF; ch++) begin
            sel = int'($urandom_range(9));
            if (sel == 0)      frm[p][ch*B +: B] = 16'h8000;
            else if (sel == 1) frm[p][ch*B +: B] = 16'h7fff;
            else               frm[p][ch*B +: B] = 16'($urandom);
         end
      end
   endtask

   // Sends frm[0..npix-1]; returns at the negedge before the last accept edge.
   task automatic drive(input int grp, input int npix, input int pv, input int pr,
                        input bit chk_lat, input bit bp);
      int            idx, cyc, bp_left;
      bit            lat_done, bp_done, vld, rdy;
      logic [PW-1:0] held;
      idx = 0; cyc = 0; bp_left = 0; lat_done = 0; bp_done = 0; held = '0;
      while (idx < npix && cyc < 4000) begin
         @(posedge clk); #1;
         vld = ($urandom_range(99) < pv);
         rdy = ($urandom_range(99) < pr);
         if (grp == 0) begin
            if (bp && !bp_done && a_out_valid) begin
               bp_left = 5;
               bp_done = 1;
               held    = a_out_act;
            end
            if (bp_left > 0) rdy = 0;
            ab_in_valid  = vld;
            ab_in_act    = frm[idx];
            ab_out_ready = rdy;
         end else begin
            c_in_valid  = vld;
            c_in_act    = frm[idx];
            c_out_ready = rdy;
         end
         @(negedge clk);
         if (grp == 0) begin
            if (chk_lat && !lat_done && a_out_valid) begin
               check("first_latency", 64'(idx), 64'd6);
               lat_done = 1;
            end
            if (bp_left > 0) begin
               check("bp_in_ready", 64'(a_in_ready), 64'd0);
               check("bp_out_valid", 64'(a_out_valid), 64'd1);
               check("bp_out_act", 64'(a_out_act), 64'(held));
               bp_left--;
            end
            if (ab_in_valid && a_in_ready) idx++;
         end else if (c_in_valid && c_in_ready) begin
            idx++;
         end
         cyc++;
      end
      if (idx < npix) check("drive_timeout", 64'(idx), 64'(npix));
   endtask

   task automatic drain(input int grp);
      int cyc, left;
      cyc = 0;
      @(posedge clk); #1;
      if (grp == 0) begin ab_in_valid = 0; ab_out_ready = 1; end
      else begin c_in_valid = 0; c_out_ready = 1; end
      left = (grp == 0) ? qa.size() + qb.size() : qc.size();
      while (left != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         left = (grp == 0) ? qa.size() + qb.size() : qc.size();
      end
      check("drain_empty", 64'(left), 64'd0);
      @(negedge clk);
      if (grp == 0) check("no_stale_valid", 64'(a_out_valid | b_out_valid), 64'd0);
      else check("no_stale_valid", 64'(c_out_valid), 64'd0);
   endtask

   // Scoreboard: a handshake seen at a negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rstn && !ab_flush && ab_out_ready) begin
         if (a_out_valid) begin
            if (qa.size() == 0) check("a_extra_out", 64'd1, 64'd0);
            else begin
               ea = qa.pop_front();
               check("a_out_act", 64'(a_out_act), 64'(ea.act));
               check("a_out_last", 64'(a_out_last), 64'(ea.last));
            end
         end
         if (b_out_valid) begin
            if (qb.size() == 0) check("b_extra_out", 64'd1, 64'd0);
            else begin
               eb = qb.pop_front();
               check("b_out_act", 64'(b_out_act), 64'(eb.act));
               check("b_out_last", 64'(b_out_last), 64'(eb.last));
            end
         end
      end
      if (rstn && !c_flush && c_out_ready && c_out_valid) begin
         if (qc.size() == 0) check("c_extra_out", 64'd1, 64'd0);
         else begin
            ec = qc.pop_front();
            check("c_out_act", 64'(c_out_act), 64'(ec.act));
            check("c_out_last", 64'(c_out_last), 64'(ec.last));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 0;
      ab_flush = 0; ab_in_valid = 0; ab_out_ready = 0; ab_in_act = '0;
      c_flush  = 0; c_in_valid  = 0; c_out_ready  = 0; c_in_act  = '0;
      #12;
      check("rst_a_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_act", 64'(a_out_act), 64'd0);
      check("rst_a_last", 64'(a_out_last), 64'd0);
      check("rst_b_valid", 64'(b_out_valid), 64'd0);
      check("rst_c_valid", 64'(c_out_valid), 64'd0);
      @(negedge clk) rstn = 1;
      @(posedge clk); #1;
      check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
      check("rst_c_in_ready", 64'(c_in_ready), 64'd1);

      // Ramp frame: max and average instances, first-output latency.
      fill_ramp(4, 4);
      push_model(0);
      drive(0, 16, 100, 100, 1, 0);
      drain(0);

      // Backpressure for five cycles on the first output.
      fill_ramp(4, 4);
      push_model(0);
      drive(0, 16, 100, 100, 0, 1);
      drain(0);

      // Overlapping windows.
      fill_ramp(3, 3);
      push_model(1);
      drive(1, 9, 100, 100, 0, 0);
      drain(1);

      // Two frames back to back.
      fill_ramp(4, 4);
      push_model(0);
      drive(0, 16, 100, 100, 0, 0);
      push_model(0);
      drive(0, 16, 100, 100, 0, 0);
      drain(0);

      // Abort a frame after six pixels with a result pending, then restart.
      fill_ramp(4, 4);
      drive(0, 6, 100, 0, 0, 0);
      @(posedge clk); #1;
      ab_in_valid = 0;
      ab_flush    = 1;
      @(negedge clk);
      check("flush_in_ready", 64'(a_in_ready), 64'd0);
      check("flush_pending", 64'(a_out_valid), 64'd1);
      @(posedge clk); #1;
      ab_flush = 0;
      @(negedge clk);
      check("flush_clr_valid_a", 64'(a_out_valid), 64'd0);
      check("flush_clr_valid_b", 64'(b_out_valid), 64'd0);
      check("flush_clr_last", 64'(a_out_last), 64'd0);
      push_model(0);
      drive(0, 16, 100, 100, 0, 0);
      drain(0);

      // Asynchronous reset with a result pending mid-frame.
      fill_ramp(4, 4);
      drive(0, 6, 100, 0, 0, 0);
      @(posedge clk); #1;
      ab_in_valid = 0;
      @(negedge clk);
      check("prerst_valid", 64'(a_out_valid), 64'd1);
      #2 rstn = 0;
      #1;
      check("midrst_a_valid", 64'(a_out_valid), 64'd0);
      check("midrst_a_act", 64'(a_out_act), 64'd0);
      check("midrst_b_valid", 64'(b_out_valid), 64'd0);
      check("midrst_b_act", 64'(b_out_act), 64'd0);
      qa.delete();
      qb.delete();
      qc.delete();
      @(negedge clk) rstn = 1;
      push_model(0);
      drive(0, 16, 100, 100, 0, 0);
      drain(0);

      // Random frames with random valid/ready patterns, several back to back.
      for (int f = 0; f < 4; f++) begin
         for (int n = 0; n < 3; n++) begin
            fill_rand(16);
            push_model(0);
            drive(0, 16, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), 0, 0);
         end
         drain(0);
         for (int n = 0; n < 3; n++) begin
            fill_rand(9);
            push_model(1);
            drive(1, 9, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), 0, 0);
         end
         drain(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
